branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 154 +++++++++++++++
 tb/tb_branch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// branch_unit: decodes MIPS-style conditional branches, resolves them and returns a registered result.
// Define BRANCH_UNIT_PREDICTOR_EN to add the 2-bit saturating counter predictor table.
module branch_unit #(
  parameter int W        = 32,
  parameter int IDX_BITS = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   ir,
  input  logic [31:0]   pc,
  input  logic [W-1:0]  rs_val,
  input  logic [W-1:0]  rt_val,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_is_branch,
  output logic          out_taken,
  output logic          out_link,
  output logic          out_mispredict
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [5:0] opcode;
  logic [4:0] rt_field;
  logic       rs_neg;
  logic       rs_zero;
  logic       dec_branch;
  logic       dec_taken;
  logic       dec_link;
  logic       pred;
  logic       capture;
  logic       handshake;

  logic valid_q, valid_d;
  logic is_branch_q, is_branch_d;
  logic taken_q, taken_d;
  logic link_q, link_d;
  logic mispredict_q, mispredict_d;

  // Fields the decoder never looks at; reduced here so they are consumed.
  logic unused_bits;
  assign unused_bits = ^{pc, ir[25:21], ir[15:0]};

  assign opcode   = ir[31:26];
  assign rt_field = ir[20:16];
  assign rs_neg   = rs_val[W-1];
  assign rs_zero  = (rs_val == '0);

  assign in_ready  = (!valid_q || out_ready) && !flush;
  assign capture   = in_valid && in_ready;
  assign handshake = valid_q && out_ready && !flush;

  always_comb begin
    dec_branch = 1'b0;
    dec_taken  = 1'b0;
    dec_link   = 1'b0;
    unique case (opcode)
      6'b000100: begin dec_branch = 1'b1; dec_taken = (rs_val == rt_val); end
      6'b000101: begin dec_branch = 1'b1; dec_taken = (rs_val != rt_val); end
      6'b000110: begin dec_branch = 1'b1; dec_taken = rs_neg || rs_zero; end
      6'b000111: begin dec_branch = 1'b1; dec_taken = !rs_neg && !rs_zero; end
      6'b000001: begin
        unique case (rt_field)
          5'b00000: begin dec_branch = 1'b1; dec_taken = rs_neg; end
          5'b00001: begin dec_branch = 1'b1; dec_taken = !rs_neg; end
          5'b10000: begin dec_branch = 1'b1; dec_taken = rs_neg;  dec_link = 1'b1; end
          5'b10001: begin dec_branch = 1'b1; dec_taken = !rs_neg; dec_link = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

`ifdef BRANCH_UNIT_PREDICTOR_EN
  logic [IDX_BITS-1:0] idx;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [1:0]          table_q [ENTRIES];
  logic [1:0]          table_d [ENTRIES];

  // Prediction reads the registered table, so a same-cycle update is never seen.
  assign idx  = pc[IDX_BITS+1:2];
  assign pred = table_q[idx][1];

  always_comb begin
    idx_d   = capture ? idx : idx_q;
    table_d = table_q;
    if (handshake && is_branch_q) begin
      if (taken_q && table_q[idx_q] != 2'b11)
        table_d[idx_q] = table_q[idx_q] + 2'd1;
      else if (!taken_q && table_q[idx_q] != 2'b00)
        table_d[idx_q] = table_q[idx_q] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      for (int i = 0; i < ENTRIES; i++)
        table_q[i] <= 2'b01;
    end else begin
      idx_q   <= idx_d;
      table_q <= table_d;
    end
  end
`else
  assign pred = 1'b0;
`endif

  always_comb begin
    valid_d      = valid_q;
    is_branch_d  = is_branch_q;
    taken_d      = taken_q;
    link_d       = link_q;
    mispredict_d = mispredict_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d      = 1'b1;
      is_branch_d  = dec_branch;
      taken_d      = dec_taken;
      link_d       = dec_link;
      mispredict_d = dec_branch && (dec_taken != pred);
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      is_branch_q  <= 1'b0;
      taken_q      <= 1'b0;
      link_q       <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      is_branch_q  <= is_branch_d;
      taken_q      <= taken_d;
      link_q       <= link_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_is_branch  = is_branch_q;
  assign out_taken      = taken_q;
  assign out_link       = link_q;
  assign out_mispredict = mispredict_q;

endmodule

// File: tb/tb_branch_unit.sv
// Testbench for branch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_unit;

  localparam int W        = 32;
  localparam int IDX_BITS = 6;
  localparam int NENT     = 1 << IDX_BITS;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   ir;
  logic [31:0]   pc;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  rt_val;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_branch;
  logic          out_taken;
  logic          out_link;
  logic          out_mispredict;

  int checks = 0;
  int errors = 0;

  bit expValid, expBranch, expTaken, expLink, expMisp;
  int expIdx;
  int cnt [NENT];

  branch_unit #(.W(W), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .pc(pc), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_branch(out_is_branch), .out_taken(out_taken),
    .out_link(out_link), .out_mispredict(out_mispredict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkIr(input int op, input int rtf);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op[5:0];
    w[20:16] = rtf[4:0];
    return w;
  endfunction

  // Branch semantics expressed as signed integer comparisons.
  function automatic void refDecode(input logic [31:0] insn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output bit isBr, output bit tk, output bit lk);
    longint sa;
    longint sb;
    int op;
    int rtf;
    sa  = $signed(a);
    sb  = $signed(b);
    op  = int'(insn[31:26]);
    rtf = int'(insn[20:16]);
    isBr = 0; tk = 0; lk = 0;
    case (op)
      4: begin isBr = 1; tk = (sa == sb); end
      5: begin isBr = 1; tk = (sa != sb); end
      6: begin isBr = 1; tk = (sa <= 0); end
      7: begin isBr = 1; tk = (sa > 0); end
      1: begin
        case (rtf)
          0:  begin isBr = 1; tk = (sa < 0); end
          1:  begin isBr = 1; tk = (sa >= 0); end
          16: begin isBr = 1; tk = (sa < 0);  lk = 1; end
          17: begin isBr = 1; tk = (sa >= 0); lk = 1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  endfunction

  task automatic modelReset();
    expValid = 0; expBranch = 0; expTaken = 0; expLink = 0; expMisp = 0; expIdx = 0;
    for (int i = 0; i < NENT; i++) cnt[i] = 1;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".out_valid"}, out_valid, expValid);
    checkOutput({tag, ".is_branch"}, out_is_branch, expBranch);
    checkOutput({tag, ".taken"}, out_taken, expTaken);
    checkOutput({tag, ".link"}, out_link, expLink);
    checkOutput({tag, ".mispredict"}, out_mispredict, expMisp);
  endtask

  // Drives one cycle of inputs, checks in_ready, advances the model across the edge and checks outputs.
  task automatic applyStimulus(input string tag, input bit vIn, input logic [31:0] insn, input logic [31:0] addr,
                               input logic [W-1:0] a, input logic [W-1:0] b, input bit fl, input bit rdy);
    bit expReady, hs, cap, br, tk, lk, pred;
    int idx;
    in_valid = vIn; ir = insn; pc = addr; rs_val = a; rt_val = b; flush = fl; out_ready = rdy;
    #1;
    expReady = (!expValid || rdy) && !fl;
    checkOutput({tag, ".in_ready"}, in_ready, expReady);
    hs  = expValid && rdy && !fl;
    cap = vIn && expReady;
    idx = int'(addr / 4) % NENT;
    refDecode(insn, a, b, br, tk, lk);
`ifdef BRANCH_UNIT_PREDICTOR_EN
    pred = (cnt[idx] >= 2);
    if (hs && expBranch) begin
      if (expTaken) cnt[expIdx] = (cnt[expIdx] < 3) ? cnt[expIdx] + 1 : 3;
      else          cnt[expIdx] = (cnt[expIdx] > 0) ? cnt[expIdx] - 1 : 0;
    end
`else
    pred = 0;
`endif
    if (fl) begin
      expValid = 0;
    end else if (cap) begin
      expValid = 1; expBranch = br; expTaken = tk; expLink = lk;
      expMisp = br && (tk != pred);
      expIdx = idx;
    end else if (hs) begin
      expValid = 0;
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  localparam logic [31:0] PC0 = 32'h0;
  localparam logic [31:0] PC40 = 32'h40;

  initial begin
    logic [31:0] insn;
    logic [W-1:0] a, b;
    int k;
    reset = 1'b0; in_valid = 0; ir = '0; pc = '0; rs_val = '0; rt_val = '0; flush = 0; out_ready = 0;
    modelReset();
    #2;
    checkAll("reset");
    #10;
    reset = 1'b1;

    // Taken beq at pc 0 from a weakly-not-taken counter.
    applyStimulus("beq_first", 1, mkIr(4, 0), PC0, 32'h1234, 32'h1234, 0, 1);
    checkOutput("beq_first.const_misp", out_mispredict, 1);
    applyStimulus("idle", 0, '0, PC0, '0, '0, 0, 1);
    applyStimulus("beq_again", 1, mkIr(4, 0), PC0, 32'h1234, 32'h1234, 0, 1);
    applyStimulus("idle", 0, '0, PC0, '0, '0, 0, 1);

    applyStimulus("blez_min", 1, mkIr(6, 0), PC0, 32'h8000_0000, '0, 0, 1);
    checkOutput("blez_min.const_taken", out_taken, 1);
    applyStimulus("bgtz_zero", 1, mkIr(7, 0), PC0, 32'h0, 32'h5, 0, 1);
    checkOutput("bgtz_zero.const_taken", out_taken, 0);
    applyStimulus("bgezal_neg", 1, mkIr(1, 17), 32'h8, 32'hFFFF_FFFF, '0, 0, 1);
    checkOutput("bgezal_neg.const_link", out_link, 1);
    applyStimulus("regimm_bad", 1, mkIr(1, 2), 32'h8, 32'h1, '0, 0, 1);
    checkOutput("regimm_bad.const_br", out_is_branch, 0);
    applyStimulus("idle", 0, '0, PC0, '0, '0, 0, 1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus("beq_pc40", 1, mkIr(4, 0), PC40, 32'h77, 32'h77, 0, 1);
      applyStimulus("idle", 0, '0, PC0, '0, '0, 0, 1);
    end

    // Back-pressure, release, then a flush that must block capture.
    applyStimulus("bp_cap", 1, mkIr(5, 0), 32'h44, 32'h1, 32'h2, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("bp_hold", 1, mkIr(4, 0), 32'h48, 32'h3, 32'h3, 0, 0);
    applyStimulus("bp_release", 0, '0, PC0, '0, '0, 0, 1);
    applyStimulus("pre_flush", 1, mkIr(4, 0), 32'h4C, 32'h9, 32'h9, 0, 0);
    applyStimulus("flush", 1, mkIr(4, 0), 32'h4C, 32'h9, 32'h9, 1, 1);
    applyStimulus("post_flush", 0, '0, PC0, '0, '0, 0, 1);

    // Asynchronous reset while a result is held.
    applyStimulus("hold_cap", 1, mkIr(4, 0), 32'h4C, 32'h9, 32'h9, 0, 0);
    applyStimulus("hold", 0, '0, PC0, '0, '0, 0, 0);
    in_valid = 0;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    #3;
    reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: insn = mkIr(4, 0);
        1: insn = mkIr(5, 0);
        2: insn = mkIr(6, 0);
        3: insn = mkIr(7, 0);
        4: insn = mkIr(1, 0);
        5: insn = mkIr(1, 1);
        6: insn = mkIr(1, 16);
        7: insn = mkIr(1, 17);
        8: insn = mkIr(1, $urandom_range(0, 31));
        default: insn = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: a = '0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 2) == 0) ? a : W'($urandom);
      applyStimulus("rand", $urandom_range(0, 4) != 0, insn, {24'h0, 3'($urandom_range(0, 7)), 5'h0} | 32'($urandom_range(0, 7) * 4),
                    a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
